// File: rtl/vec_pkg.sv
// Shared vector-unit types.
// Holds the lane count, the lane word width, the store FSM state encoding,
// the lane index type and the lane word type used by vstore_unit.
package vec_pkg;
  localparam int LANES  = 4;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} vstore_state_t;
  typedef logic [1:0]        lane_idx_t;
  typedef logic [DATA_W-1:0] lane_word_t;
endpackage

// File: rtl/vstore_unit.sv
// Vector store unit.
// Accepts one 4-lane strided store (base, stride, data, mask) via valid/ready
// and serialises it into one word write per cycle on the data-memory write
// port. Each lane takes exactly one cycle whether or not it is masked. A
// one-cycle done pulse follows the last lane. err reports whether any enabled
// lane addressed beyond MEM_DEPTH, and holds until the next accept.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_base, req_stride      lane-0 word address, two's-complement word stride
//   req_data, req_mask        lane i data at [i*DATA_W +: DATA_W], lane enables
//   we, waddr, wdata          registered memory write port
//   done, err                 completion pulse, sticky out-of-range flag
module vstore_unit
  import vec_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_base,
  input  logic [ADDR_W-1:0]       req_stride,
  input  logic [LANES*DATA_W-1:0] req_data,
  input  logic [LANES-1:0]        req_mask,
  output logic                    we,
  output logic [ADDR_W-1:0]       waddr,
  output logic [DATA_W-1:0]       wdata,
  output logic                    done,
  output logic                    err
);

  vstore_state_t                     state_q, state_d;
  lane_idx_t                         lane_q, lane_d;
  logic [ADDR_W-1:0]                 stride_q, stride_d;
  logic [LANES-1:0][DATA_W-1:0]      data_q, data_d;
  logic [LANES-1:0]                  mask_q, mask_d;
  logic [ADDR_W-1:0]                 waddr_q, waddr_d;
  lane_word_t                        wdata_q, wdata_d;
  logic                              we_q, we_d;
  logic                              done_q, done_d;
  logic                              err_q, err_d;
  logic                              flag_q, flag_d;
  logic [ADDR_W-1:0]                 addr_nxt;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return a < ADDR_W'(MEM_DEPTH);
  endfunction

  assign req_ready = (state_q == IDLE) && !rst;

  // waddr_q doubles as the running address accumulator: each lane is the
  // previous lane's address plus stride, wrapping modulo 2^ADDR_W.
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    stride_d = stride_q;
    data_d   = data_q;
    mask_d   = mask_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    flag_d   = flag_q;
    addr_nxt = waddr_q + stride_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          // Lane 0 is presented straight from the request so that it appears
          // in the first cycle after accept.
          stride_d = req_stride;
          data_d   = req_data;
          mask_d   = req_mask;
          lane_d   = '0;
          waddr_d  = req_base;
          wdata_d  = req_data[DATA_W-1:0];
          we_d     = req_mask[0] && in_range(req_base);
          flag_d   = req_mask[0] && !in_range(req_base);
          err_d    = 1'b0;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        if (lane_q == lane_idx_t'(LANES-1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = flag_q;
        end else begin
          lane_d  = lane_q + 2'd1;
          waddr_d = addr_nxt;
          wdata_d = data_q[lane_d];
          we_d    = mask_q[lane_d] && in_range(addr_nxt);
          flag_d  = flag_q || (mask_q[lane_d] && !in_range(addr_nxt));
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lane_q   <= '0;
      stride_q <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      stride_q <= stride_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      done_q   <= done_d;
      err_q    <= err_d;
      flag_q   <= flag_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_vstore_unit.sv
module tb_vstore_unit;
  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_base, req_stride;
  logic [127:0] req_data;
  logic [3:0]   req_mask;
  logic         we;
  logic [31:0]  waddr, wdata;
  logic         done, err;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic        exp_err;

  vstore_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_base(req_base), .req_stride(req_stride), .req_data(req_data),
    .req_mask(req_mask), .we(we), .waddr(waddr), .wdata(wdata),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Scoreboard: every observed write must match the oldest expected write.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      logic [63:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected: got addr=%h data=%h, none expected", waddr, wdata);
      end else begin
        e = exp_q.pop_front();
        if ({waddr, wdata} !== e) begin
          failures++;
          $display("FAIL write_value: got addr=%h data=%h, expected addr=%h data=%h",
                   waddr, wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  // Drives a request at the current negedge and pushes the expected writes of
  // the first nl lanes (model: address accumulates by stride, wraps at 2^32).
  task automatic drive_req(input logic [31:0] b, input logic [31:0] s,
                           input logic [127:0] d, input logic [3:0] m, input int nl);
    logic [31:0] a;
    a = b;
    exp_err = 1'b0;
    req_base = b; req_stride = s; req_data = d; req_mask = m; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        if (a < 32'd1024) begin
          if (i < nl) exp_q.push_back({a, d[i*32 +: 32]});
        end else exp_err = 1'b1;
      end
      a = a + s;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1;
    req_base = 32'h5; req_stride = 32'h1; req_data = '1; req_mask = 4'hF;
    repeat (3) @(negedge clk);
    checks++;
    if ({we, waddr, wdata, done, err} !== 67'd0) begin
      failures++;
      $display("FAIL reset_outputs: got we=%b waddr=%h wdata=%h done=%b err=%b, expected all 0",
               we, waddr, wdata, done, err);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 0", req_ready);
    end
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || we !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: got ready=%b we=%b expected 1/0", req_ready, we);
    end
  endtask

  // Walks one request from its accept cycle A through A+6.
  task automatic test_pattern(input string nm, input logic [31:0] b, input logic [31:0] s,
                              input logic [127:0] d, input logic [3:0] m);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_A: got %b expected 1", nm, req_ready);
    end
    drive_req(b, s, d, m, 4);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (req_ready !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL %s_busy_A%0d: got ready=%b done=%b expected 0/0", nm, i, req_ready, done);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || err !== exp_err || we !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_A5: got done=%b err=%b we=%b ready=%b expected 1/%b/0/0",
               nm, done, err, we, req_ready, exp_err);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || err !== exp_err || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_after_A6: got done=%b err=%b ready=%b expected 0/%b/1",
               nm, done, err, req_ready, exp_err);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_writes: got %0d pending expected 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_unit_stride();
    test_pattern("unit", 32'h10, 32'h1, {32'hD, 32'hC, 32'hB, 32'hA}, 4'hF);
  endtask

  task automatic test_masked();
    test_pattern("masked", 32'h10, 32'h1, {32'hD, 32'hC, 32'hB, 32'hA}, 4'b0101);
    test_pattern("mask0", 32'h10, 32'h1, {32'hD, 32'hC, 32'hB, 32'hA}, 4'b0000);
  endtask

  task automatic test_neg_stride();
    test_pattern("negstride", 32'h20, 32'hFFFF_FFFF, {32'h44, 32'h33, 32'h22, 32'h11}, 4'hF);
  endtask

  task automatic test_out_of_range();
    test_pattern("oor", 32'h3FE, 32'h1, {32'h4, 32'h3, 32'h2, 32'h1}, 4'hF);
    repeat (2) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL oor_err_held: got %b expected 1", err);
    end
  endtask

  // Two requests with req_valid held high; runs right after the out-of-range
  // test so the first accept must clear a set err.
  task automatic test_back_to_back();
    logic e2;
    drive_req(32'h100, 32'h4, {32'h13, 32'h12, 32'h11, 32'h10}, 4'hF, 4);
    @(negedge clk); // A+1
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_err_clear: got %b expected 0", err);
    end
    drive_req(32'h3FD, 32'h2, {32'h23, 32'h22, 32'h21, 32'h20}, 4'b1011, 4);
    e2 = exp_err;
    for (int i = 1; i <= 5; i++) begin
      checks++;
      if (req_ready !== 1'b0 || done !== (i == 5)) begin
        failures++;
        $display("FAIL b2b_first_A%0d: got ready=%b done=%b expected 0/%b", i, req_ready, done, i == 5);
      end
      @(negedge clk);
    end
    checks++; // A+6: second request accepted at the end of this cycle
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready_A6: got %b expected 1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 7; i <= 11; i++) begin
      checks++;
      if (done !== (i == 11)) begin
        failures++;
        $display("FAIL b2b_second_A%0d: got done=%b expected %b", i, done, i == 11);
      end
      if (i == 11) begin
        checks++;
        if (err !== e2) begin
          failures++;
          $display("FAIL b2b_second_err: got %b expected %b", err, e2);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_missing_writes: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_op();
    drive_req(32'h40, 32'h1, {32'h7, 32'h6, 32'h5, 32'h4}, 4'hF, 2);
    @(negedge clk); // A+1
    req_valid = 1'b0;
    @(negedge clk); // A+2
    rst = 1'b1;
    @(negedge clk); // A+3
    checks++;
    if (we !== 1'b0 || done !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_A3: got we=%b done=%b ready=%b expected 0/0/0", we, done, req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_ready: got %b expected 1", req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (done !== 1'b0 || we !== 1'b0) begin
        failures++;
        $display("FAIL midrst_quiet%0d: got done=%b we=%b expected 0/0", i, done, we);
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL midrst_missing_writes: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0;
    req_base = '0; req_stride = '0; req_data = '0; req_mask = '0;
    @(negedge clk);
    test_reset();
    test_unit_stride();
    test_masked();
    test_neg_stride();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vstore_unit.md
Name: vstore_unit

Overview:
Vector store unit: the write-side counterpart to the 4-port combinational data-memory read path. Accepts one 4-lane vector store request (base, stride, lane data, lane mask) through a valid/ready handshake. Serialises the request into one word write per cycle on the data-memory write port. Signals completion with a single-cycle done pulse. Sits between the vector execute stage and the data-memory write port.

Parameters:
LANES, 4, number of vector lanes; fixed at 4 for this revision.
DATA_W, 32, lane and memory word width in bits.
ADDR_W, 32, word-address width.
MEM_DEPTH, 1024, number of memory words; lane addresses >= MEM_DEPTH are out of range.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset; synchronous, active-high.
req_valid  in  1  store request present.
req_ready  out  1  unit can accept a request.
req_base  in  ADDR_W  word address of lane 0.
req_stride  in  ADDR_W  word stride between lanes, two's complement.
req_data  in  LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
req_mask  in  LANES  bit i=1 enables the lane i write.
we  out  1  memory write enable.
waddr  out  ADDR_W  memory word address.
wdata  out  DATA_W  memory write data.
done  out  1  one-cycle pulse when the request has completed.
err  out  1  sticky out-of-range flag for the last completed request.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; we=0, waddr=0, wdata=0, done=0, err=0. req_ready=0 while rst is high.
- FSM states: IDLE, WRITE, DONE.
- IDLE: req_ready=1. An accept occurs on a cycle (call it A) with req_valid&req_ready. On accept, latch base/stride/data/mask, set lane=0, clear err, go to WRITE.
- WRITE: exactly one cycle per lane, regardless of mask. Lane i is presented in cycle A+1+i.
  - we/waddr/wdata are registered outputs.
  - waddr = base + i*stride, kept as a running accumulator, modulo 2^ADDR_W (wrap, no saturation).
  - we=1 only if mask[i]=1 and waddr < MEM_DEPTH (unsigned compare).
  - If mask[i]=1 and the address is out of range: we=0 for that lane and an internal error flag is set.
  - When we=0, waddr/wdata still show the lane's values; the consumer ignores them.
  - After lane LANES-1, go to DONE.
- DONE (cycle A+LANES+1): done=1, we=0, req_ready=0. err takes the internal flag value. Next state is IDLE.
- Latency: a request accepted at cycle A produces writes at A+1..A+4 and done at A+5. The next accept is possible at A+6. req_ready=0 from A+1 through A+5.
- Request inputs are sampled only at accept. Changes while busy are ignored.
- Mask 4'b0000: still walks 4 WRITE cycles with we=0 throughout, then done; err=0.
- err holds its value after DONE until the next accept, which clears it.
- Reset mid-operation: state returns to IDLE at that edge and we=0 from the next cycle. Remaining lanes are dropped and done is not pulsed. Writes already issued are not undone.
- Simultaneous rst and req_valid: reset wins; the request is not accepted.

Decomposition:
- Shared package vec_pkg:
  - LANES and DATA_W constants;
  - vstore_state_t enum {IDLE, WRITE, DONE};
  - lane index type (2 bits);
  - lane_word_t typedef.
- No sub-module is needed: the accumulator, lane counter and FSM fit in one module.

Test Plan:
1. Unit stride: base=0x10, stride=1, data lanes {0xA,0xB,0xC,0xD}, mask=4'hF -> (0x10,0xA),(0x11,0xB),(0x12,0xC),(0x13,0xD) with we=1 at A+1..A+4; done=1 at A+5; err=0.
2. Masked: same request with mask=4'b0101 -> we=1 only at A+1 (0x10,0xA) and A+3 (0x12,0xC); done at A+5; err=0.
3. Negative stride: base=0x20, stride=0xFFFFFFFF -> waddr 0x20,0x1F,0x1E,0x1D in order, all we=1.
4. Out of range: base=0x3FE, stride=1, mask=4'hF -> writes only at 0x3FE and 0x3FF; we=0 at A+3 and A+4; err=1 at A+5 and held until next accept.
5. Back-to-back: req_valid held high with two distinct requests -> req_ready=0 over A+1..A+5; second accept at A+6; its writes at A+7..A+10.
6. Reset mid-op: rst=1 during cycle A+2 -> we=0 from A+3; no done pulse; req_ready=1 in the first cycle after rst deasserts.
